pipe_reg_de: RTL
================

Name: pipe_reg_de

Overview:
- D/E pipeline register of the five-stage MIPS pipeline.
- Captures the decoded instruction, PC, forwarded operands, extended immediate, destination register and hazard timing from D.
- Presents them to the E-stage control decoder and ALU.
- Also produces the movz condition flag changeE, inserts bubbles on stall/flush, and freezes its contents on hold.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word loaded for a bubble (sll $0,$0,0).
- RESET_PC, 32'h0000_3000, pcE value after reset and for bubbles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears register to bubble state.
- hold  input  1  freeze E contents (multi-cycle E unit busy).
- stall  input  1  D-stage hazard stall; load a bubble into E.
- flush  input  1  kill the instruction entering E; load a bubble.
- instrD  input  32  D-stage instruction word.
- pcD  input  32  D-stage PC.
- rsdD  input  32  forwarded rs value at D.
- rtdD  input  32  forwarded rt value at D.
- extD  input  32  sign/zero/lui-extended immediate.
- a3D  input  5  destination register (0 = no write).
- tnewD  input  2  cycles until the result is available, counted at E entry.
- instrE  output  32  E instruction, to the E-stage decoder.
- pcE  output  32  E PC.
- pc8E  output  32  pcE + 8 (jal/jalr link value).
- rsdE  output  32  rs operand.
- rtdE  output  32  rt operand.
- extE  output  32  immediate.
- a3E  output  5  effective destination register.
- tnewE  output  2  registered tnewD.
- changeE  output  1  1 = movz condition failed (rt != 0); the E decoder then does not select the movz ALU op.
- validE  output  1  1 = E holds a real instruction, 0 = bubble.

Behaviour:
- Single register bank; all outputs are registered except pc8E, which is combinational pcE + 8 with 32-bit wrap.
- Update priority at each rising clk edge:
  - 1. reset
  - 2. hold
  - 3. flush or stall
  - 4. normal load
- Bubble state, loaded on reset, flush or stall:
  - instrE = NOP_INSTR, pcE = RESET_PC.
  - rsdE = rtdE = extE = 0, a3E = 0, tnewE = 0.
  - changeE = 0, validE = 0.
  - After reset, pc8E = RESET_PC + 8.
- hold (reset low): every register keeps its value, and stall/flush are ignored that cycle.
  - The upstream hazard unit must also freeze F/D during hold; this block does not check that.
- Normal load (reset, hold, stall, flush all low):
  - Every field is copied from its D counterpart; validE = 1.
- movz detection:
  - movzD = (instrD[31:26] == 6'b000000) and (instrD[5:0] == 6'b001010) and (instrD[10:6] == 0).
  - On load, changeE <= movzD and (rtdD != 0).
  - On load, a3E <= a3D when movzD is 0 or rtdD == 0; a3E <= 0 when changeE is set (suppresses the write).
- tnewE is copied unmodified; no decrement in this stage (M stage decrements).
- Simultaneous stall and flush: a single bubble, same as either alone.
- Reset during hold: reset wins and the bubble is loaded.
- The outputs are always defined; no X propagation from bubbles.
- Latency: exactly one cycle from D inputs to E outputs when not held.

Test Plan:
- Reset: reset=1 for 2 cycles, then 0 with stall=1 → instrE=0, pcE=32'h3000, pc8E=32'h3008, validE=0, a3E=0.
- Normal load: instrD=32'h3421_0005 (ori), pcD=32'h3004, rsdD=7, extD=5, a3D=1, tnewD=1 → next cycle all fields equal, validE=1, changeE=0, pc8E=32'h300C.
- movz with rt=0: instrD=32'h0043_080A, rtdD=0, a3D=1 → changeE=0, a3E=1.
- movz with rt nonzero: same instruction, rtdD=5 → changeE=1, a3E=0.
- Stall vs hold priority:
  - Load instr A, then stall=1 → bubble (validE=0).
  - Load instr B, then hold=1 and stall=1 for 3 cycles → instrE stays B for all 3 cycles.
- Flush and reset during hold: flush=1 and stall=1 together → single bubble. hold=1 and reset=1 together → bubble next cycle.

Source files
------------

// File: rtl/pipe_reg_de_if.sv
// D-to-E stage bundle: pipeline control, D-stage fields going in and E-stage fields coming out.
// The upstream side drives hold/stall/flush and the D fields; the register drives the E fields.
interface pipe_reg_de_if;
  logic        hold;
  logic        stall;
  logic        flush;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] rsdD;
  logic [31:0] rtdD;
  logic [31:0] extD;
  logic [4:0]  a3D;
  logic [1:0]  tnewD;
  logic [31:0] instrE;
  logic [31:0] pcE;
  logic [31:0] pc8E;
  logic [31:0] rsdE;
  logic [31:0] rtdE;
  logic [31:0] extE;
  logic [4:0]  a3E;
  logic [1:0]  tnewE;
  logic        changeE;
  logic        validE;

  modport master (
    output hold, stall, flush, instrD, pcD, rsdD, rtdD, extD, a3D, tnewD,
    input  instrE, pcE, pc8E, rsdE, rtdE, extE, a3E, tnewE, changeE, validE
  );

  modport slave (
    input  hold, stall, flush, instrD, pcD, rsdD, rtdD, extD, a3D, tnewD,
    output instrE, pcE, pc8E, rsdE, rtdE, extE, a3E, tnewE, changeE, validE
  );
endinterface

// File: rtl/pipe_reg_de.sv
// D/E pipeline register: loads decoded D-stage fields, inserts bubbles on stall/flush,
// freezes on hold, and resolves the movz condition into changeE and the effective a3E.
module pipe_reg_de #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
  input logic           clk,
  input logic           reset,
  pipe_reg_de_if.slave  bus
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] rsd_q,   rsd_d;
  logic [31:0] rtd_q,   rtd_d;
  logic [31:0] ext_q,   ext_d;
  logic [4:0]  a3_q,    a3_d;
  logic [1:0]  tnew_q,  tnew_d;
  logic        change_q, change_d;
  logic        valid_q,  valid_d;
  logic        movz_d;
  logic        movz_fail_d;

  // movz only writes when rt == 0; otherwise the write is cancelled here so E needs no extra logic.
  assign movz_d = (bus.instrD[31:26] == 6'b000000) &&
                  (bus.instrD[5:0]   == 6'b001010) &&
                  (bus.instrD[10:6]  == 5'b00000);
  assign movz_fail_d = movz_d && (bus.rtdD != 32'h0);

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    rsd_d    = rsd_q;
    rtd_d    = rtd_q;
    ext_d    = ext_q;
    a3_d     = a3_q;
    tnew_d   = tnew_q;
    change_d = change_q;
    valid_d  = valid_q;
    if (!bus.hold) begin
      if (bus.stall || bus.flush) begin
        instr_d  = NOP_INSTR;
        pc_d     = RESET_PC;
        rsd_d    = 32'h0;
        rtd_d    = 32'h0;
        ext_d    = 32'h0;
        a3_d     = 5'd0;
        tnew_d   = 2'd0;
        change_d = 1'b0;
        valid_d  = 1'b0;
      end else begin
        instr_d  = bus.instrD;
        pc_d     = bus.pcD;
        rsd_d    = bus.rsdD;
        rtd_d    = bus.rtdD;
        ext_d    = bus.extD;
        a3_d     = movz_fail_d ? 5'd0 : bus.a3D;
        tnew_d   = bus.tnewD;
        change_d = movz_fail_d;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= NOP_INSTR;
      pc_q     <= RESET_PC;
      rsd_q    <= 32'h0;
      rtd_q    <= 32'h0;
      ext_q    <= 32'h0;
      a3_q     <= 5'd0;
      tnew_q   <= 2'd0;
      change_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rsd_q    <= rsd_d;
      rtd_q    <= rtd_d;
      ext_q    <= ext_d;
      a3_q     <= a3_d;
      tnew_q   <= tnew_d;
      change_q <= change_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.instrE  = instr_q;
  assign bus.pcE     = pc_q;
  assign bus.pc8E    = pc_q + 32'd8;
  assign bus.rsdE    = rsd_q;
  assign bus.rtdE    = rtd_q;
  assign bus.extE    = ext_q;
  assign bus.a3E     = a3_q;
  assign bus.tnewE   = tnew_q;
  assign bus.changeE = change_q;
  assign bus.validE  = valid_q;

endmodule
